// File: rtl/sht10_display.sv
// SHT10 result to 7-segment display: raw word -> fixed-point value -> clamp ->
// sequential double-dabble BCD -> 4-digit multiplexed dd.dd display.
module sht10_display #(
  parameter int SCAN_BITS = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] raw_data,
  input  logic        data_valid,
  input  logic        temp_rh_sel,
  input  logic        com_error,
  output logic        busy,
  output logic [3:0]  anode,
  output logic [7:0]  led_code
);

  typedef enum logic [2:0] {IDLE, CALC, CLAMP, CONV, LOAD} state_t;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  state_t                state_q;
  logic [13:0]           raw_q;
  logic                  sel_q;
  logic signed [17:0]    v_q;
  logic [29:0]           dd_q;
  logic [3:0]            cnt_q;
  logic                  oor_q;
  logic [15:0]           disp_q;
  logic                  disp_oor_q;
  logic                  disp_vld_q;
  logic                  busy_q;
  logic [SCAN_BITS-1:0]  scan_q;
  logic [3:0]            anode_q;
  logic [7:0]            led_q;

  // Fixed-point conversion terms
  logic [23:0]        rh_prod;
  logic signed [17:0] v_temp_d;
  logic signed [17:0] v_rh_d;

  assign rh_prod  = 24'(raw_q[11:0]) * 24'd3758;
  assign v_temp_d = $signed({4'b0000, raw_q}) - 18'sd3970;
  assign v_rh_d   = $signed({4'b0000, rh_prod[23:10]}) - 18'sd205;

  // Range rules: temperature flags out-of-range, RH saturates
  logic [13:0] mag_d;
  logic        oor_d;

  always_comb begin
    mag_d = v_q[13:0];
    oor_d = 1'b0;
    if (!sel_q) begin
      if (v_q < 18'sd0 || v_q > 18'sd9999) begin
        oor_d = 1'b1;
        mag_d = 14'd0;
      end
    end else begin
      if (v_q < 18'sd0)         mag_d = 14'd0;
      else if (v_q > 18'sd9999) mag_d = 14'd9999;
    end
  end

  // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left
  logic [29:0] dd_adj;
  logic [29:0] dd_d;

  always_comb begin
    dd_adj = dd_q;
    for (int k = 0; k < 4; k++) begin
      if (dd_q[14+4*k +: 4] >= 4'd5)
        dd_adj[14+4*k +: 4] = dd_q[14+4*k +: 4] + 4'd3;
    end
    dd_d = {dd_adj[28:0], 1'b0};
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Display mux for the digit currently selected by the scan counter
  logic [1:0] idx;
  logic [3:0] digit;
  logic [3:0] anode_d;
  logic [7:0] led_d;

  assign idx     = scan_q[SCAN_BITS-1 -: 2];
  assign digit   = disp_q[4*idx +: 4];
  assign anode_d = ~(4'b0001 << idx);

  always_comb begin
    led_d = SEG_BLANK;
    if (com_error) begin
      case (idx)
        2'd3:    led_d = SEG_E;
        2'd2:    led_d = SEG_R;
        2'd1:    led_d = SEG_R;
        default: led_d = SEG_BLANK;
      endcase
    end else if (!disp_vld_q) begin
      led_d = SEG_BLANK;
    end else if (disp_oor_q) begin
      led_d = SEG_DASH;
    end else begin
      led_d = seg7(digit) & ((idx == 2'd2) ? 8'h7F : 8'hFF);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      raw_q      <= '0;
      sel_q      <= 1'b0;
      v_q        <= '0;
      dd_q       <= '0;
      cnt_q      <= '0;
      oor_q      <= 1'b0;
      disp_q     <= '0;
      disp_oor_q <= 1'b0;
      disp_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      scan_q     <= '0;
      anode_q    <= 4'b1111;
      led_q      <= SEG_BLANK;
    end else begin
      scan_q  <= scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
      anode_q <= anode_d;
      led_q   <= led_d;
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            raw_q   <= temp_rh_sel ? {2'b00, raw_data[11:0]} : raw_data[13:0];
            sel_q   <= temp_rh_sel;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          v_q     <= sel_q ? v_rh_d : v_temp_d;
          state_q <= CLAMP;
        end
        CLAMP: begin
          dd_q    <= {16'd0, mag_d};
          oor_q   <= oor_d;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          dd_q  <= dd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state_q <= LOAD;
        end
        LOAD: begin
          disp_q     <= dd_q[29:14];
          disp_oor_q <= oor_q;
          disp_vld_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign anode    = anode_q;
  assign led_code = led_q;

endmodule

// File: tb/tb_sht10_display.sv
// Directed bench for sht10_display with a 4-bit scan counter.
module tb_sht10_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] raw_data = '0;
  logic        data_valid = 1'b0;
  logic        temp_rh_sel = 1'b0;
  logic        com_error = 1'b0;
  logic        busy;
  logic [3:0]  anode;
  logic [7:0]  led_code;

  int checks = 0;
  int passed = 0;

  sht10_display #(.SCAN_BITS(4)) dut (
    .clock(clock), .reset(reset), .raw_data(raw_data), .data_valid(data_valid),
    .temp_rh_sel(temp_rh_sel), .com_error(com_error), .busy(busy),
    .anode(anode), .led_code(led_code)
  );

  always #5 clock = ~clock;

  // Collect the code shown on each anode; codes = {d3,d2,d1,d0}
  task automatic read_disp(output logic [31:0] codes, output logic ok);
    logic [3:0] seen;
    seen  = 4'h0;
    codes = '1;
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      @(negedge clock);
      for (int k = 0; k < 4; k++)
        if (anode == ~(4'b0001 << k)) begin
          codes[8*k +: 8] = led_code;
          seen[k] = 1'b1;
        end
    end
    ok = (seen == 4'hF);
  endtask

  // Caller is positioned just after a negedge; strobe and count busy cycles
  task automatic run_conv(input logic [15:0] raw, input logic sel, output int nb);
    raw_data = raw; temp_rh_sel = sel; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      nb++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    logic [3:0] s[16];
    logic       pat_ok, blank_ok;
    logic [3:0] seen;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (anode !== 4'b1111) $display("FAIL rst_anode got %b exp 1111", anode); else passed++;
    checks++; if (led_code !== 8'hFF) $display("FAIL rst_led got %h exp ff", led_code); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    reset = 1'b1;
    blank_ok = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      s[i] = anode;
      if (led_code !== 8'hFF) blank_ok = 1'b0;
      for (int k = 0; k < 4; k++) if (anode == ~(4'b0001 << k)) seen[k] = 1'b1;
    end
    pat_ok = (seen == 4'hF);
    for (int i = 0; i < 16; i++) begin
      if (s[i] !== s[i & ~3]) pat_ok = 1'b0;
      if (i > 0 && (i % 4) == 0 && s[i] === s[i-1]) pat_ok = 1'b0;
    end
    checks++; if (!pat_ok) $display("FAIL scan_pattern got %b %b %b %b exp one-hot-low, 4 cycles each", s[0], s[4], s[8], s[12]); else passed++;
    checks++; if (!blank_ok) $display("FAIL scan_blank got non-ff code exp ff"); else passed++;
  endtask

  task automatic test_temp;
    int nb; logic [31:0] c; logic ok;
    run_conv(16'h1B76, 1'b0, nb);
    checks++; if (nb != 17) $display("FAIL temp_busy got %0d exp 17", nb); else passed++;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hB04082C0) $display("FAIL temp_7030 got %h exp b04082c0", c); else passed++;
  endtask

  task automatic test_range;
    int nb; logic [31:0] c; logic ok;
    run_conv(16'd3000, 1'b0, nb);
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hBFBFBFBF) $display("FAIL temp_low got %h exp bfbfbfbf", c); else passed++;
    run_conv(16'd16383, 1'b0, nb);
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hBFBFBFBF) $display("FAIL temp_high got %h exp bfbfbfbf", c); else passed++;
  endtask

  task automatic test_rh;
    int nb; logic [31:0] c; logic ok;
    run_conv(16'd1000, 1'b1, nb);
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hB0198299) $display("FAIL rh_1000 got %h exp b0198299", c); else passed++;
    run_conv(16'd4095, 1'b1, nb);
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'h90109090) $display("FAIL rh_sat got %h exp 90109090", c); else passed++;
    run_conv(16'hF00A, 1'b1, nb);  // upper bits must be ignored -> raw 10
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hC040C0C0) $display("FAIL rh_neg got %h exp c040c0c0", c); else passed++;
  endtask

  task automatic test_back_to_back;
    int nb; logic [31:0] c; logic ok;
    raw_data = 16'd1000; temp_rh_sel = 1'b1; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (4) @(negedge clock);
    raw_data = 16'h1B76; temp_rh_sel = 1'b0; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      @(negedge clock);
    end
    checks++; if (nb != 12) $display("FAIL b2b_busy got %0d exp 12", nb); else passed++;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hB0198299) $display("FAIL b2b_drop got %h exp b0198299", c); else passed++;
    // Second strobe at the earliest legal edge
    run_conv(16'd10, 1'b1, nb);
    run_conv(16'h1B76, 1'b0, nb);
    checks++; if (nb != 17) $display("FAIL e18_busy got %0d exp 17", nb); else passed++;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hB04082C0) $display("FAIL e18_accept got %h exp b04082c0", c); else passed++;
  endtask

  task automatic test_com_error;
    logic [31:0] c; logic ok;
    raw_data = 16'd4095; temp_rh_sel = 1'b1; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (3) @(negedge clock);
    com_error = 1'b1;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'h86AFAFFF) $display("FAIL com_err got %h exp 86afafff", c); else passed++;
    repeat (4) @(negedge clock);
    com_error = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL com_busy_timeout got %b exp 0", busy); else passed++;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'h90109090) $display("FAIL com_after got %h exp 90109090", c); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] c; logic ok;
    raw_data = 16'h1B76; temp_rh_sel = 1'b0; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else passed++;
    checks++; if (anode !== 4'b1111 || led_code !== 8'hFF) $display("FAIL mid_rst_out got %b/%h exp 1111/ff", anode, led_code); else passed++;
    @(negedge clock);
    reset = 1'b1;
    read_disp(c, ok);
    checks++; if (!ok || c !== 32'hFFFFFFFF) $display("FAIL mid_rst_blank got %h exp ffffffff", c); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_idle got %b exp 0", busy); else passed++;
  endtask

  initial begin
    test_reset;
    test_temp;
    test_range;
    test_rh;
    test_back_to_back;
    test_com_error;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
